// File: rtl/rpn_calculator_param_if.sv
// ---------------------------------------------------------------------------
// rpn_calculator_param_if
//
// Purpose: bundles the command strobes and status outputs of the RPN
// calculator so the button/switch front-end and the display logic can be
// wired to the engine through a single port.
//
// Signals:
//   enter        front-end -> engine  push strobe for `data`
//   op_valid     front-end -> engine  operation strobe for `op`
//   op           front-end -> engine  00 add, 01 sub, 10 mul, 11 div
//   data         front-end -> engine  operand value, IN_WIDTH bits
//   clear_error  front-end -> engine  clears the sticky error flags
//   result       engine -> display    current top of stack (0 when empty)
//   depth        engine -> display    number of valid stack entries
//   busy         engine -> display    operation in progress
//   overflow     engine -> display    status of the last completed op
//   error        engine -> display    sticky error flags
//
// Modports: master = front-end side, slave = calculator engine side.
// ---------------------------------------------------------------------------
interface rpn_calculator_param_if #(
    parameter int IN_WIDTH = 8,
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8
);
    localparam int DW = $clog2(DEPTH + 1);

    logic                enter;
    logic                op_valid;
    logic [1:0]          op;
    logic [IN_WIDTH-1:0] data;
    logic                clear_error;
    logic [WIDTH-1:0]    result;
    logic [DW-1:0]       depth;
    logic                busy;
    logic                overflow;
    logic [3:0]          error;

    modport master (
        output enter, op_valid, op, data, clear_error,
        input  result, depth, busy, overflow, error
    );

    modport slave (
        input  enter, op_valid, op, data, clear_error,
        output result, depth, busy, overflow, error
    );
endinterface

// File: rtl/rpn_calculator_param.sv
// ---------------------------------------------------------------------------
// rpn_calculator_param
//
// Purpose: parametrised RPN stack engine. Operands are pushed with `enter`;
// an operation pops b (top) then a (next), and pushes the ALU result of
// a <op> b three cycles after the op is accepted. Errors are sticky flags.
//
// Ports:
//   clock  rising-edge system clock
//   reset  synchronous, active-high; clears stack, FSM and flags
//   bus    rpn_calculator_param_if.slave (strobes in, result/status out)
//
// Parameters: IN_WIDTH (operand input width), WIDTH (stack/ALU width),
//             DEPTH (stack entries, >= 2).
//
// Build option: define RPN_CALCULATOR_DIV_EN to enable op 11 as unsigned
// division; otherwise op 11 is rejected as illegal and no divider exists.
// ---------------------------------------------------------------------------
module rpn_calculator_param #(
    parameter int IN_WIDTH = 8,
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    rpn_calculator_param_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef RPN_CALCULATOR_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, POP_B, POP_A, PUSH} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [DW-1:0]    depth_q, depth_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic             overflow_q, overflow_d;
    logic [3:0]       error_q, error_d;

    logic [AW-1:0]      top_idx, push_idx;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf, alu_div0;
    logic               illegal_op;

    // Depth counts entries, so the top lives one below it and a push
    // lands exactly at it.
    assign top_idx  = AW'(depth_q - DW'(1));
    assign push_idx = AW'(depth_q);

    assign bus.result   = (depth_q == '0) ? '0 : stack_q[top_idx];
    assign bus.depth    = depth_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.overflow = overflow_q;
    assign bus.error    = error_q;

    // ALU: works on the latched operands, only consumed in PUSH.
    // Overflow means carry out, borrow, or nonzero upper product half.
    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        prod     = (2*WIDTH)'(a_q) * (2*WIDTH)'(b_q);
        alu_res  = '0;
        alu_ovf  = 1'b0;
        alu_div0 = 1'b0;
        case (op_q)
            2'b00: begin
                alu_res = sum[WIDTH-1:0];
                alu_ovf = sum[WIDTH];
            end
            2'b01: begin
                alu_res = a_q - b_q;
                alu_ovf = (a_q < b_q);
            end
            2'b10: begin
                alu_res = prod[WIDTH-1:0];
                alu_ovf = |prod[2*WIDTH-1:WIDTH];
            end
            default: begin
`ifdef RPN_CALCULATOR_DIV_EN
                // Divide by zero yields all-ones and flags an error.
                if (b_q == '0) begin
                    alu_res  = '1;
                    alu_div0 = 1'b1;
                end else begin
                    alu_res = a_q / b_q;
                end
`else
                alu_res = '0;
`endif
            end
        endcase
    end

    // Next-state logic. Clear_error is applied first so any error raised
    // in the same cycle still ends up set.
    always_comb begin
        state_d    = state_q;
        stack_d    = stack_q;
        depth_d    = depth_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        overflow_d = overflow_q;
        error_d    = bus.clear_error ? 4'b0000 : error_q;
        illegal_op = (bus.op == 2'b11) && !DIV_EN;

        case (state_q)
            IDLE: begin
                if (bus.enter) begin
                    // Enter wins a collision with op_valid; op is dropped.
                    if (bus.op_valid) error_d[2] = 1'b1;
                    if (depth_q < DW'(DEPTH)) begin
                        stack_d[push_idx] = WIDTH'(bus.data);
                        depth_d           = depth_q + DW'(1);
                    end else begin
                        error_d[0] = 1'b1;
                    end
                end else if (bus.op_valid) begin
                    if (illegal_op)          error_d[3] = 1'b1;
                    if (depth_q < DW'(2))    error_d[1] = 1'b1;
                    if (!illegal_op && depth_q >= DW'(2)) begin
                        op_d    = bus.op;
                        state_d = POP_B;
                    end
                end
            end
            POP_B: begin
                b_d     = stack_q[top_idx];
                depth_d = depth_q - DW'(1);
                state_d = POP_A;
            end
            POP_A: begin
                a_d     = stack_q[top_idx];
                depth_d = depth_q - DW'(1);
                state_d = PUSH;
            end
            PUSH: begin
                stack_d[push_idx] = alu_res;
                depth_d           = depth_q + DW'(1);
                overflow_d        = alu_ovf;
                if (alu_div0) error_d[3] = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Any command arriving mid-operation is ignored but reported.
        if (state_q != IDLE && (bus.enter || bus.op_valid)) error_d[2] = 1'b1;
    end

    // State and datapath registers with synchronous reset; reset during an
    // operation simply abandons it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            depth_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 2'b00;
            overflow_q <= 1'b0;
            error_q    <= 4'b0000;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            overflow_q <= overflow_d;
            error_q    <= error_d;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
        end
    end
endmodule

// File: tb/tb_rpn_calculator_param.sv
// ---------------------------------------------------------------------------
// tb_rpn_calculator_param
//
// Directed scenarios for the RPN engine followed by a randomized command
// stream checked against a queue-based stack model.
// ---------------------------------------------------------------------------
module tb_rpn_calculator_param;
    localparam int IN_WIDTH = 8;
    localparam int WIDTH    = 16;
    localparam int DEPTH    = 8;
`ifdef RPN_CALCULATOR_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    rpn_calculator_param_if #(.IN_WIDTH(IN_WIDTH), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    rpn_calculator_param #(.IN_WIDTH(IN_WIDTH), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the stack as a queue, top at the back.
    logic [WIDTH-1:0] mq[$];
    logic             mov;
    logic [3:0]       merr;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic ov, input logic [1:0] op,
                                 input logic [IN_WIDTH-1:0] d, input logic clr);
        bus.enter       = en;
        bus.op_valid    = ov;
        bus.op          = op;
        bus.data        = d;
        bus.clear_error = clr;
        tick();
        bus.enter       = 1'b0;
        bus.op_valid    = 1'b0;
        bus.clear_error = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        checkOutput("idle_reached", bus.busy, 0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        bus.enter = 1'b0; bus.op_valid = 1'b0; bus.op = 2'b00;
        bus.data = '0; bus.clear_error = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        mq.delete();
        mov  = 1'b0;
        merr = 4'b0000;
    endtask

    task automatic push(input logic [IN_WIDTH-1:0] d);
        applyStimulus(1'b1, 1'b0, 2'b00, d, 1'b0);
    endtask

    task automatic modelEnter(input logic [IN_WIDTH-1:0] d);
        if (mq.size() < DEPTH) mq.push_back(WIDTH'(d));
        else merr[0] = 1'b1;
    endtask

    // Returns whether the operation is accepted (will run three cycles).
    task automatic modelOp(input logic [1:0] op, output bit accepted);
        longint a, b, r;
        bit illegal;
        illegal  = (op == 2'b11) && !DIV_EN;
        accepted = !illegal && mq.size() >= 2;
        if (illegal)      merr[3] = 1'b1;
        if (mq.size() < 2) merr[1] = 1'b1;
        if (accepted) begin
            b = longint'(mq.pop_back());
            a = longint'(mq.pop_back());
            case (op)
                2'b00: begin r = a + b; mov = (r >= (64'd1 << WIDTH)); end
                2'b01: begin r = a - b; mov = (a < b); end
                2'b10: begin r = a * b; mov = ((r >> WIDTH) != 0); end
                default: begin
                    mov = 1'b0;
                    if (b == 0) begin r = (64'd1 << WIDTH) - 1; merr[3] = 1'b1; end
                    else r = a / b;
                end
            endcase
            mq.push_back(WIDTH'(r));
        end
    endtask

    task automatic checkModel(input string tag);
        logic [WIDTH-1:0] top;
        top = (mq.size() == 0) ? '0 : mq[$];
        checkOutput({tag, "_result"},   bus.result,   top);
        checkOutput({tag, "_depth"},    bus.depth,    mq.size());
        checkOutput({tag, "_overflow"}, bus.overflow, mov);
        checkOutput({tag, "_error"},    bus.error,    merr);
        checkOutput({tag, "_busy"},     bus.busy,     0);
    endtask

    initial begin
        int  cyc;
        int  kind;
        bit  acc;
        logic [IN_WIDTH-1:0] rd;
        logic [1:0] rop;
        logic rclr;

        $display("[TB] starting");
        // Reset state.
        doReset();
        checkOutput("rst_result",   bus.result,   0);
        checkOutput("rst_depth",    bus.depth,    0);
        checkOutput("rst_busy",     bus.busy,     0);
        checkOutput("rst_overflow", bus.overflow, 0);
        checkOutput("rst_error",    bus.error,    0);

        // 5 + 3 with three busy cycles.
        push(8'h05); push(8'h03);
        applyStimulus(1'b0, 1'b1, 2'b00, 8'h00, 1'b0);
        waitIdle(cyc);
        checkOutput("add_busy_cycles", cyc, 3);
        checkOutput("add_result", bus.result, 16'h0008);
        checkOutput("add_depth",  bus.depth, 1);
        checkOutput("add_ovf",    bus.overflow, 0);

        // 3 - 5 borrows, then * 2 overflows.
        doReset();
        push(8'h03); push(8'h05);
        applyStimulus(1'b0, 1'b1, 2'b01, 8'h00, 1'b0);
        waitIdle(cyc);
        checkOutput("sub_result", bus.result, 16'hFFFE);
        checkOutput("sub_ovf",    bus.overflow, 1);
        push(8'h02);
        applyStimulus(1'b0, 1'b1, 2'b10, 8'h00, 1'b0);
        waitIdle(cyc);
        checkOutput("mul_result", bus.result, 16'hFFFC);
        checkOutput("mul_ovf",    bus.overflow, 1);
        checkOutput("mul_depth",  bus.depth, 1);

        // Fill the stack, then push once more.
        doReset();
        for (int i = 0; i < DEPTH; i++) push(8'hFF);
        checkOutput("full_depth", bus.depth, DEPTH);
        checkOutput("full_error_before", bus.error, 0);
        push(8'h11);
        checkOutput("full_push_depth",  bus.depth, DEPTH);
        checkOutput("full_push_error",  bus.error, 4'b0001);
        checkOutput("full_push_result", bus.result, 16'h00FF);
        applyStimulus(1'b0, 1'b0, 2'b00, 8'h00, 1'b1);
        checkOutput("clear_error", bus.error, 0);
        // Clear coinciding with a new error leaves the new error set.
        applyStimulus(1'b1, 1'b0, 2'b00, 8'h22, 1'b1);
        checkOutput("clear_vs_new", bus.error, 4'b0001);

        // Underflow with a single entry.
        doReset();
        push(8'h07);
        applyStimulus(1'b0, 1'b1, 2'b00, 8'h00, 1'b0);
        checkOutput("uflow_busy",   bus.busy, 0);
        checkOutput("uflow_error",  bus.error, 4'b0010);
        checkOutput("uflow_depth",  bus.depth, 1);
        checkOutput("uflow_result", bus.result, 16'h0007);

        // Enter while busy is ignored.
        doReset();
        push(8'h01); push(8'h02);
        applyStimulus(1'b0, 1'b1, 2'b00, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 8'h09, 1'b0);
        waitIdle(cyc);
        checkOutput("busy_enter_error",  bus.error, 4'b0100);
        checkOutput("busy_enter_depth",  bus.depth, 1);
        checkOutput("busy_enter_result", bus.result, 16'h0003);

        // Enter and op together: enter wins, collision flagged.
        doReset();
        push(8'h04);
        applyStimulus(1'b1, 1'b1, 2'b00, 8'h06, 1'b0);
        checkOutput("collide_depth",  bus.depth, 2);
        checkOutput("collide_result", bus.result, 16'h0006);
        checkOutput("collide_error",  bus.error, 4'b0100);
        checkOutput("collide_busy",   bus.busy, 0);

        // Reset during an operation aborts it.
        doReset();
        push(8'h04); push(8'h06);
        applyStimulus(1'b0, 1'b1, 2'b00, 8'h00, 1'b0);
        tick();
        doReset();
        checkOutput("abort_depth", bus.depth, 0);
        checkOutput("abort_busy",  bus.busy, 0);
        tick(); tick(); tick();
        checkOutput("abort_no_push", bus.depth, 0);

        // Op 11: division or illegal depending on the build.
        doReset();
        push(8'h14); push(8'h00);
        applyStimulus(1'b0, 1'b1, 2'b11, 8'h00, 1'b0);
        waitIdle(cyc);
        checkOutput("div0_error", bus.error, 4'b1000);
        checkOutput("div0_depth", bus.depth, DIV_EN ? 1 : 2);
        checkOutput("div0_result", bus.result, DIV_EN ? 16'hFFFF : 16'h0000);
        doReset();
        push(8'h14); push(8'h04);
        applyStimulus(1'b0, 1'b1, 2'b11, 8'h00, 1'b0);
        waitIdle(cyc);
        checkOutput("div_result", bus.result, DIV_EN ? 16'h0005 : 16'h0004);
        checkOutput("div_error",  bus.error, DIV_EN ? 4'b0000 : 4'b1000);

        // Randomized command stream against the queue model.
        doReset();
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 9);
            rd   = IN_WIDTH'($urandom);
            rop  = 2'($urandom);
            rclr = ($urandom_range(0, 7) == 0);
            if (rclr) merr = 4'b0000;
            if (kind <= 3) begin
                modelEnter(rd);
                applyStimulus(1'b1, 1'b0, rop, rd, rclr);
            end else if (kind <= 7) begin
                modelOp(rop, acc);
                applyStimulus(1'b0, 1'b1, rop, rd, rclr);
                if (acc && $urandom_range(0, 3) == 0) begin
                    merr[2] = 1'b1;
                    applyStimulus($urandom_range(0, 1) == 1, 1'b1, 2'($urandom), IN_WIDTH'($urandom), 1'b0);
                end
                waitIdle(cyc);
            end else if (kind == 8) begin
                modelEnter(rd);
                merr[2] = 1'b1;
                applyStimulus(1'b1, 1'b1, rop, rd, rclr);
            end else begin
                applyStimulus(1'b0, 1'b0, rop, rd, rclr);
            end
            checkModel("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rpn_calculator_param.md
Name: rpn_calculator_param

Overview:
- Parametrised successor of the team's stack calculator: an RPN engine with configurable data width and stack depth.
- Adds subtract, explicit stack-depth reporting, full/underflow/busy/illegal-op error detection and a busy indication.
- Sits between the board button/switch front-end and the seven-segment/LED display logic.
- Operands are pushed with `enter`; an operation pops two entries and pushes the result.

Parameters:
- IN_WIDTH, 8, width of the `data` input; zero-extended to WIDTH on push.
- WIDTH, 16, stack entry and result width; also the ALU width.
- DEPTH, 8, number of stack entries; minimum 2.

Ports:
- clock  input  1  single system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clears stack, FSM, flags
- enter  input  1  single-cycle strobe: push zero-extended `data`
- op_valid  input  1  single-cycle strobe: execute `op` on the top two entries
- op  input  2  00 add, 01 sub, 10 mul, 11 div (optional feature only)
- data  input  IN_WIDTH  operand value sampled with `enter`
- clear_error  input  1  single-cycle strobe: clears `error`
- result  output  WIDTH  current top of stack; 0 when the stack is empty
- depth  output  $clog2(DEPTH+1)  number of valid entries
- busy  output  1  high while an operation is in progress (FSM not in IDLE)
- overflow  output  1  registered status of the last completed op
- error  output  4  sticky flags: [0] push while full, [1] underflow, [2] command while busy or enter+op collision, [3] illegal op or divide by zero

Behaviour:
- Reset, synchronous and active-high, takes effect at the next rising `clock` edge:
  - result=0, depth=0, busy=0, overflow=0, error=0, FSM=IDLE.
  - Reset asserted mid-operation aborts the operation with no push.
- Stack: register array with a top pointer.
  - `result` is the registered/combinational view of the top entry.
  - Push and pop each take effect in one cycle.
- FSM states and transitions:
  - IDLE: waits for `enter` or `op_valid`.
  - POP_B: latch b = top, pop.
  - POP_A: latch a = new top, pop.
  - PUSH: push the ALU result, update `overflow`, then return to IDLE.
- Op accepted in IDLE at cycle T:
  - T+1: POP_B.
  - T+2: POP_A.
  - T+3: PUSH.
  - Result visible on `result` and `depth` after the T+3 edge, i.e. 3-cycle latency.
  - `busy`=1 during POP_B, POP_A and PUSH.
- Operand order: a is the deeper entry, b is the top. Sub computes a-b; div computes a/b.
- Arithmetic is unsigned and truncated to WIDTH. `overflow` is set when:
  - add carries out,
  - sub borrows (a<b),
  - mul has nonzero upper WIDTH bits.
- `overflow` holds its value until the next op completes. Div never sets `overflow`.
- `enter` in IDLE:
  - depth<DEPTH: push {zero-extension, data}, depth+1.
  - depth==DEPTH: no push, stack unchanged, error[0] set.
- `op_valid` in IDLE with depth<2: no state change, error[1] set.
- `enter` and `op_valid` in the same cycle in IDLE: enter is processed, op is dropped, error[2] set.
- `enter` or `op_valid` while busy: ignored, error[2] set.
- Illegal op: op==11 with the feature absent is rejected in IDLE. No pop, error[3] set.
- Error flags:
  - Each bit is sticky until `clear_error` or reset.
  - If `clear_error` coincides with a new error, the new error wins (bit ends set).
- Net depth after a successful op: depth-1.

Optional Feature:
- Macro: RPN_CALCULATOR_DIV_EN.
- Defined:
  - op 11 = unsigned division a/b, computed combinationally in PUSH; latency is unchanged.
  - b==0: push all-ones, set error[3].
- Undefined:
  - No divider is synthesised.
  - op 11 is rejected as illegal (no pop, error[3]).

Test Plan:
- Push 0x05, push 0x03, op add (WIDTH=16) -> busy high 3 cycles; result 0x0008, depth 1, overflow 0.
- Push 0x03, push 0x05, op sub -> result 0xFFFE, overflow 1; then push 0x02 and op mul -> result 0xFFFC, overflow 1.
- Push 0xFF eight times (DEPTH=8), then a ninth enter -> depth stays 8, error[0]=1; clear_error -> error 0.
- Reset, push 0x07, op add -> error[1]=1, depth 1, result 0x0007, busy never asserted.
- During busy of an add, pulse enter with data 0x09 -> enter ignored, error[2]=1, final depth 1 with the sum on top.
- Div: with the macro, push 0x14, push 0x00, op div -> result 0xFFFF, error[3]=1; push 0x14, push 0x04, op div -> 0x0005. Without the macro, op 11 -> error[3]=1, depth unchanged.
